// File: rtl/alu_stage_ctrl.sv
// Multi-cycle control FSM for the ALU stage: fetch, decode, execute, memory, write-back.
// Outputs are decoded from the registered state and the opcode latched in S_DECODE.
module alu_stage_ctrl (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [31:0] Instr,
  input  logic        Zero,
  input  logic        Mem_Ack,
  output logic        IR_WrEn,
  output logic        PC_LdEn,
  output logic        PC_sel,
  output logic [1:0]  ImmExt,
  output logic        ALU_Bin_sel,
  output logic        lui,
  output logic [3:0]  ALU_func,
  output logic        RF_WrEn,
  output logic        RF_WrData_sel,
  output logic        MEM_WrEn,
  output logic        Mem_Req
);

  localparam int unsigned OP_W   = 6;
  localparam int unsigned FUNC_W = 4;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b100000;
  localparam logic [OP_W-1:0] OP_LI    = 6'b111000;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b111001;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b110000;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b110010;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b110011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000000;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000001;
  localparam logic [OP_W-1:0] OP_B     = 6'b111111;
  localparam logic [OP_W-1:0] OP_LW    = 6'b001111;
  localparam logic [OP_W-1:0] OP_SW    = 6'b011111;

  localparam logic [FUNC_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [FUNC_W-1:0] ALU_SUB = 4'b0001;
  localparam logic [FUNC_W-1:0] ALU_AND = 4'b0010;
  localparam logic [FUNC_W-1:0] ALU_OR  = 4'b0011;

  localparam logic [1:0] IMM_SEXT    = 2'b00;
  localparam logic [1:0] IMM_ZEXT    = 2'b01;
  localparam logic [1:0] IMM_SEXT_SH = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WR,
    S_WB,
    S_BRANCH,
    S_PCINC
  } state_t;

  state_t              state_q;
  logic [OP_W-1:0]     opcode_q;
  logic [OP_W-1:0]     instr_op;
  logic [FUNC_W-1:0]   instr_func;
  logic                unused_instr;

  assign instr_op     = Instr[31:26];
  assign instr_func   = Instr[3:0];
  assign unused_instr = ^Instr[25:4];

  // State sequencing and opcode latch; the decode target uses the live opcode
  // because the latch only takes effect at the end of S_DECODE.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= S_IDLE;
      opcode_q <= '0;
    end else begin
      case (state_q)
        S_IDLE:   state_q <= S_FETCH;
        S_FETCH:  if (Mem_Ack) state_q <= S_DECODE;
        S_DECODE: begin
          opcode_q <= instr_op;
          case (instr_op)
            OP_RTYPE:                                  state_q <= S_EXEC_R;
            OP_LI, OP_LUI, OP_ADDI, OP_ANDI, OP_ORI:   state_q <= S_EXEC_I;
            OP_LW, OP_SW:                              state_q <= S_MEM_ADDR;
            OP_BEQ, OP_BNE, OP_B:                      state_q <= S_BRANCH;
            default:                                   state_q <= S_PCINC;
          endcase
        end
        S_EXEC_R:   state_q <= S_WB;
        S_EXEC_I:   state_q <= S_WB;
        S_MEM_ADDR: state_q <= (opcode_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   if (Mem_Ack) state_q <= S_WB;
        S_MEM_WR:   if (Mem_Ack) state_q <= S_PCINC;
        S_WB:       state_q <= S_FETCH;
        S_BRANCH:   state_q <= S_FETCH;
        S_PCINC:    state_q <= S_FETCH;
        default:    state_q <= S_IDLE;
      endcase
    end
  end

  // Moore output decode; IR_WrEn follows the fetch ack and PC_sel follows Zero in S_BRANCH.
  always_comb begin
    IR_WrEn       = 1'b0;
    PC_LdEn       = 1'b0;
    PC_sel        = 1'b0;
    ImmExt        = IMM_SEXT;
    ALU_Bin_sel   = 1'b0;
    lui           = 1'b0;
    ALU_func      = ALU_ADD;
    RF_WrEn       = 1'b0;
    RF_WrData_sel = 1'b0;
    MEM_WrEn      = 1'b0;
    Mem_Req       = 1'b0;
    case (state_q)
      S_FETCH: begin
        Mem_Req = 1'b1;
        IR_WrEn = Mem_Ack;
      end
      S_EXEC_R: begin
        ALU_Bin_sel = 1'b0;
        ALU_func    = instr_func;
      end
      S_EXEC_I: begin
        ALU_Bin_sel = 1'b1;
        case (opcode_q)
          OP_LUI:  lui = 1'b1;
          OP_ANDI: begin
            ImmExt   = IMM_ZEXT;
            ALU_func = ALU_AND;
          end
          OP_ORI: begin
            ImmExt   = IMM_ZEXT;
            ALU_func = ALU_OR;
          end
          default: ALU_func = ALU_ADD;
        endcase
      end
      S_MEM_ADDR: ALU_Bin_sel = 1'b1;
      S_MEM_RD: begin
        ALU_Bin_sel = 1'b1;
        Mem_Req     = 1'b1;
      end
      S_MEM_WR: begin
        ALU_Bin_sel = 1'b1;
        Mem_Req     = 1'b1;
        MEM_WrEn    = 1'b1;
      end
      S_WB: begin
        RF_WrEn       = 1'b1;
        PC_LdEn       = 1'b1;
        RF_WrData_sel = (opcode_q == OP_LW);
      end
      S_BRANCH: begin
        ALU_func = ALU_SUB;
        ImmExt   = IMM_SEXT_SH;
        PC_LdEn  = 1'b1;
        case (opcode_q)
          OP_BEQ:  PC_sel = Zero;
          OP_BNE:  PC_sel = ~Zero;
          default: PC_sel = 1'b1;
        endcase
      end
      S_PCINC: PC_LdEn = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_stage_ctrl.sv
// Directed bench for alu_stage_ctrl: per-cycle output vectors checked against hand-derived values.
module tb_alu_stage_ctrl;

  logic        Clk;
  logic        Reset_n;
  logic [31:0] Instr;
  logic        Zero;
  logic        Mem_Ack;
  logic        IR_WrEn, PC_LdEn, PC_sel, ALU_Bin_sel, lui;
  logic [1:0]  ImmExt;
  logic [3:0]  ALU_func;
  logic        RF_WrEn, RF_WrData_sel, MEM_WrEn, Mem_Req;

  int total;
  int bad;

  alu_stage_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .Instr(Instr), .Zero(Zero), .Mem_Ack(Mem_Ack),
    .IR_WrEn(IR_WrEn), .PC_LdEn(PC_LdEn), .PC_sel(PC_sel), .ImmExt(ImmExt),
    .ALU_Bin_sel(ALU_Bin_sel), .lui(lui), .ALU_func(ALU_func), .RF_WrEn(RF_WrEn),
    .RF_WrData_sel(RF_WrData_sel), .MEM_WrEn(MEM_WrEn), .Mem_Req(Mem_Req)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // {IR, PC_Ld, PC_sel, ImmExt[1:0], Bin_sel, lui, func[3:0], RF_Wr, RF_sel, MEM_Wr, Req}
  logic [14:0] outs;
  assign outs = {IR_WrEn, PC_LdEn, PC_sel, ImmExt, ALU_Bin_sel, lui, ALU_func,
                 RF_WrEn, RF_WrData_sel, MEM_WrEn, Mem_Req};

  function automatic logic [14:0] ev(input logic ir, input logic pcld, input logic pcsel,
                                     input logic [1:0] imm, input logic bsel, input logic lu,
                                     input logic [3:0] fn, input logic rfwr, input logic rfsel,
                                     input logic memwr, input logic req);
    return {ir, pcld, pcsel, imm, bsel, lu, fn, rfwr, rfsel, memwr, req};
  endfunction

  localparam logic [14:0] M_ALL   = 15'h7fff;
  localparam logic [14:0] M_NOIMM = 15'h73ff;
  localparam logic [14:0] M_CTRL  = 15'h700f;

  task automatic check(input string tag, input logic [14:0] exp, input logic [14:0] msk);
    total++;
    assert ((outs & msk) === (exp & msk))
      else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, outs & msk, exp & msk);
      end
  endtask

  // Advance one clock, drive this cycle's inputs, then check the settled outputs.
  task automatic cyc(input string tag, input logic ack, input logic z,
                     input logic [14:0] exp, input logic [14:0] msk);
    @(posedge Clk);
    #1;
    Mem_Ack = ack;
    Zero    = z;
    #1;
    check(tag, exp, msk);
  endtask

  initial begin
    logic [14:0] e_f1, e_f0, e_z, e_wb, e_addr, e_rd, e_inc;
    total = 0;
    bad   = 0;
    e_f1   = ev(1, 0, 0, 2'b00, 0, 0, 4'h0, 0, 0, 0, 1);
    e_f0   = ev(0, 0, 0, 2'b00, 0, 0, 4'h0, 0, 0, 0, 1);
    e_z    = '0;
    e_wb   = ev(0, 1, 0, 2'b00, 0, 0, 4'h0, 1, 0, 0, 0);
    e_addr = ev(0, 0, 0, 2'b00, 1, 0, 4'h0, 0, 0, 0, 0);
    e_rd   = ev(0, 0, 0, 2'b00, 1, 0, 4'h0, 0, 0, 0, 1);
    e_inc  = ev(0, 1, 0, 2'b00, 0, 0, 4'h0, 0, 0, 0, 0);

    Reset_n = 1'b0;
    Instr   = 32'h8022_0001;
    Zero    = 1'b0;
    Mem_Ack = 1'b0;
    #3;
    check("reset_held", e_z, M_ALL);
    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    #1;
    check("idle_after_release", e_z, M_ALL);

    // R-type sub, Mem_Ack on first request
    cyc("r_fetch", 1, 0, e_f1, M_ALL);
    cyc("r_decode", 1, 0, e_z, M_ALL);
    cyc("r_exec", 1, 0, ev(0, 0, 0, 2'b00, 0, 0, 4'b0001, 0, 0, 0, 0), M_ALL);
    cyc("r_wb", 1, 0, e_wb, M_ALL);

    // lui (ImmExt unconstrained)
    Instr = {6'b111001, 26'h000_1234};
    cyc("lui_fetch", 1, 0, e_f1, M_ALL);
    cyc("lui_decode", 0, 0, e_z, M_ALL);
    cyc("lui_exec", 0, 0, ev(0, 0, 0, 2'b00, 1, 1, 4'b0000, 0, 0, 0, 0), M_NOIMM);
    cyc("lui_wb", 0, 0, e_wb, M_ALL);

    // andi, with one stall cycle in fetch
    Instr = {6'b110010, 26'h000_00ff};
    cyc("andi_fetch_wait", 0, 0, e_f0, M_ALL);
    cyc("andi_fetch", 1, 0, e_f1, M_ALL);
    cyc("andi_decode", 1, 0, e_z, M_ALL);
    cyc("andi_exec", 1, 0, ev(0, 0, 0, 2'b01, 1, 0, 4'b0010, 0, 0, 0, 0), M_ALL);
    cyc("andi_wb", 1, 0, e_wb, M_ALL);

    // ori
    Instr = {6'b110011, 26'h000_000f};
    cyc("ori_fetch", 1, 0, e_f1, M_ALL);
    cyc("ori_decode", 1, 0, e_z, M_ALL);
    cyc("ori_exec", 1, 0, ev(0, 0, 0, 2'b01, 1, 0, 4'b0011, 0, 0, 0, 0), M_ALL);
    cyc("ori_wb", 1, 0, e_wb, M_ALL);

    // lw with three stall cycles on the data read: 8 cycles total
    Instr = {6'b001111, 26'h000_0010};
    cyc("lw_fetch", 1, 0, e_f1, M_ALL);
    cyc("lw_decode", 1, 0, e_z, M_ALL);
    cyc("lw_addr", 1, 0, e_addr, M_ALL);
    cyc("lw_rd_wait1", 0, 0, e_rd, M_ALL);
    cyc("lw_rd_wait2", 0, 0, e_rd, M_ALL);
    cyc("lw_rd_wait3", 0, 0, e_rd, M_ALL);
    cyc("lw_rd_ack", 1, 0, e_rd, M_ALL);
    cyc("lw_wb", 1, 0, ev(0, 1, 0, 2'b00, 0, 0, 4'h0, 1, 1, 0, 0), M_ALL);
    cyc("lw_next_fetch", 1, 0, e_f1, M_ALL);

    // beq taken (Zero=1)
    Instr = {6'b000000, 26'h000_0004};
    cyc("beq_decode", 1, 1, e_z, M_ALL);
    cyc("beq_branch", 1, 1, ev(0, 1, 1, 2'b10, 0, 0, 4'b0001, 0, 0, 0, 0), M_ALL);

    // bne not taken (Zero=1)
    Instr = {6'b000001, 26'h000_0004};
    cyc("bne_fetch", 1, 1, e_f1, M_ALL);
    cyc("bne_decode", 1, 1, e_z, M_ALL);
    cyc("bne_branch", 1, 1, ev(0, 1, 0, 2'b10, 0, 0, 4'b0001, 0, 0, 0, 0), M_ALL);

    // b always taken, Zero=0
    Instr = {6'b111111, 26'h000_0008};
    cyc("b_fetch", 1, 0, e_f1, M_ALL);
    cyc("b_decode", 1, 0, e_z, M_ALL);
    cyc("b_branch", 1, 0, ev(0, 1, 1, 2'b10, 0, 0, 4'b0001, 0, 0, 0, 0), M_ALL);

    // illegal opcode: straight to PC increment
    Instr = {6'b010101, 26'h000_0000};
    cyc("ill_fetch", 1, 0, e_f1, M_ALL);
    cyc("ill_decode", 1, 0, e_z, M_ALL);
    cyc("ill_pcinc", 1, 0, e_inc, M_ALL);

    // sw completing normally
    Instr = {6'b011111, 26'h000_0020};
    cyc("sw_fetch", 1, 0, e_f1, M_ALL);
    cyc("sw_decode", 1, 0, e_z, M_ALL);
    cyc("sw_addr", 1, 0, e_addr, M_ALL);
    cyc("sw_wr_ack", 1, 0, ev(0, 0, 0, 2'b00, 0, 0, 4'h0, 0, 0, 1, 1), M_CTRL);
    cyc("sw_pcinc", 1, 0, e_inc, M_ALL);

    // sw aborted by reset while waiting in the write state
    cyc("sw2_fetch", 1, 0, e_f1, M_ALL);
    cyc("sw2_decode", 1, 0, e_z, M_ALL);
    cyc("sw2_addr", 0, 0, e_addr, M_ALL);
    cyc("sw2_wr_wait", 0, 0, ev(0, 0, 0, 2'b00, 0, 0, 4'h0, 0, 0, 1, 1), M_CTRL);
    #1;
    Reset_n = 1'b0;
    #1;
    check("abort_reset_immediate", e_z, M_ALL);
    Mem_Ack = 1'b1;
    @(posedge Clk);
    #2;
    check("abort_reset_held", e_z, M_ALL);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    #1;
    check("abort_idle_after_release", e_z, M_ALL);
    cyc("abort_fetch", 0, 0, e_f0, M_ALL);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_stage_ctrl.md
# alu_stage_ctrl

Multi-cycle control FSM that sequences the ALU stage and the surrounding datapath for one instruction at a time: fetch, decode, execute, memory, write-back. It sits beside the datapath and drives the ALU operand-B mux select, the lui operand select, the 4-bit ALU function, register-file, memory and PC enables. It consumes the instruction word, the ALU Zero flag and a memory acknowledge. All outputs are Moore-decoded from the registered state plus the latched opcode.

## Interface

- No parameters.
- Clk  in  1  rising-edge clock
- Reset_n  in  1  asynchronous, active-low reset
- Instr  in  32  current instruction word; opcode = Instr[31:26], func = Instr[3:0]
- Zero  in  1  ALU zero flag
- Mem_Ack  in  1  memory access complete (instruction or data)
- IR_WrEn  out  1  load instruction register
- PC_LdEn  out  1  load PC
- PC_sel  out  1  0 = PC+4, 1 = PC+4+branch offset
- ImmExt  out  2  00 sign-extend, 01 zero-extend, 10 sign-extend shifted left 2
- ALU_Bin_sel  out  1  0 = RF_B, 1 = immediate path
- lui  out  1  1 = select lui operand on immediate path
- ALU_func  out  4  ALU operation
- RF_WrEn  out  1  register-file write
- RF_WrData_sel  out  1  0 = ALU result, 1 = memory data
- MEM_WrEn  out  1  data-memory write
- Mem_Req  out  1  memory access request

## Operation

- Opcode latched into an internal 6-bit register in S_DECODE; it stays stable until the next S_DECODE.
- ALU codes: 0000 add, 0001 sub, 0010 and, 0011 or.
- Opcodes: 100000 R-type; 111000 li; 111001 lui; 110000 addi; 110010 andi; 110011 ori; 000000 beq; 000001 bne; 111111 b; 001111 lw; 011111 sw. Any other opcode is illegal.
- S_IDLE: all outputs 0. Next state is S_FETCH.
- S_FETCH: Mem_Req=1; IR_WrEn=Mem_Ack. Stays in S_FETCH until Mem_Ack, then goes to S_DECODE.
- S_DECODE: all enables 0. Next state by opcode:
  - R-type goes to S_EXEC_R.
  - li, lui and the immediate ALU ops go to S_EXEC_I.
  - lw and sw go to S_MEM_ADDR.
  - beq, bne and b go to S_BRANCH.
  - Illegal opcodes go to S_PCINC.
- S_EXEC_R: ALU_Bin_sel=0, ALU_func=func. Next state S_WB.
- S_EXEC_I: ALU_Bin_sel=1. Next state S_WB.
  - li: add, ImmExt=00.
  - lui: lui=1, add.
  - addi: add, ImmExt=00.
  - andi: and, ImmExt=01.
  - ori: or, ImmExt=01.
  - li adds to RF_A, and the datapath zeroes RF_A for li.
- S_MEM_ADDR: ALU_Bin_sel=1, ImmExt=00, add. Next state is S_MEM_RD for lw, S_MEM_WR for sw.
- S_MEM_RD: Mem_Req=1, address outputs held. Waits for Mem_Ack, then goes to S_WB with RF_WrData_sel=1 latched.
- S_MEM_WR: Mem_Req=1, MEM_WrEn=1. Waits for Mem_Ack, then goes to S_PCINC.
- S_WB: RF_WrEn=1 and PC_LdEn=1 for exactly one cycle, PC_sel=0. RF_WrData_sel=1 only when the opcode is lw. Next state S_FETCH.
- S_BRANCH: ALU_Bin_sel=0, sub, ImmExt=10, PC_LdEn=1. Next state S_FETCH.
  - beq: PC_sel=Zero.
  - bne: PC_sel=~Zero.
  - b: PC_sel=1.
- S_PCINC: PC_LdEn=1, PC_sel=0. Next state S_FETCH.

## Timing

- Reset_n low asynchronously forces S_IDLE and clears the opcode register. Every output is 0 while reset is held and on the first cycle after release.
- Reset asserted mid-instruction aborts it. No RF, memory or PC write may occur after the reset edge.
- Cycles from S_FETCH entry to return to S_FETCH, with Mem_Ack high on first request:
  - R-type and immediate instructions: 4.
  - Branch: 3.
  - lw: 5.
  - sw: 5.
  - Illegal opcode: 3.
- Each cycle Mem_Ack is low in S_FETCH, S_MEM_RD or S_MEM_WR adds one cycle. Outputs are held constant while waiting.
- Mem_Ack outside those three states is ignored.
- RF_WrEn, PC_LdEn and IR_WrEn are never high for more than one consecutive cycle per instruction.
- MEM_WrEn stays high from S_MEM_WR entry until the Mem_Ack cycle inclusive.
- Zero is sampled only in S_BRANCH.

## Test plan

- Reset: hold Reset_n=0 mid-S_MEM_WR -> MEM_WrEn drops immediately. After release, one S_IDLE cycle with all outputs 0, then Mem_Req=1.
- R-type: Instr=0x8022_0001 (opcode 100000, func 0001), Mem_Ack=1 -> ALU_Bin_sel=0 and ALU_func=0001 in cycle 3. RF_WrEn=PC_LdEn=1 in cycle 4. Mem_Req=1 in cycle 5.
- lui: opcode 111001 -> in S_EXEC_I, ALU_Bin_sel=1, lui=1, ALU_func=0000. andi (110010) -> ImmExt=01, ALU_func=0010.
- lw with stall: opcode 001111, Mem_Ack low 3 cycles in S_MEM_RD -> Mem_Req held for 4 cycles. Then RF_WrEn=1 with RF_WrData_sel=1 for exactly one cycle; total 8 cycles.
- Branches: beq with Zero=1 -> PC_sel=1, PC_LdEn=1. bne with Zero=1 -> PC_sel=0. b -> PC_sel=1 regardless of Zero. Each instruction takes 3 cycles.
- Illegal opcode 010101 -> no RF_WrEn or MEM_WrEn; PC_LdEn=1 with PC_sel=0 in cycle 3.
